// File: rtl/memory_arbiter.sv
// memory_arbiter: two requesters share one single-port memory unit.
// A four-state FSM (IDLE, WR, RD_SETUP, RD_CAPTURE) serialises accesses.
// Every output is registered.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin conflict resolution.
// Without the macro, requester 0 always wins a conflict.
//
// Handshake: a requester raises reqN together with weN/addrN/wdataN and holds
// all of them until it sees gntN. gntN is a one-cycle pulse meaning the
// request was latched, so the requester may change or drop its inputs after
// that. doneN pulses once when the access has completed. For a read, rdata is
// valid in that cycle and keeps its value until the next read completes.
// A req still high in the done cycle is taken as a fresh request.
module memory_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mem_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, WR, RD_SETUP, RD_CAPTURE} state_t;

    state_t            state, state_n;
    logic              owner, owner_n;   // requester being served (0 or 1)
    logic              gnt0_n, gnt1_n, done0_n, done1_n, mem_rw_n;
    logic [DATA_W-1:0] rdata_n, mem_in_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              pick1;            // requester 1 wins this IDLE cycle
    logic              win_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prio, prio_n;                  // 1: requester 1 is favoured on a conflict

    // Round-robin winner: the requester not granted most recently
    always_comb begin
        pick1 = req1 && (!req0 || prio);
    end
`else
    // Fixed priority: requester 0 always wins
    always_comb begin
        pick1 = req1 && !req0;
    end
`endif

    assign dbg_state = state;

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        gnt0_n     = 1'b0;
        gnt1_n     = 1'b0;
        done0_n    = 1'b0;
        done1_n    = 1'b0;
        mem_rw_n   = 1'b0;
        mem_addr_n = mem_addr;
        mem_in_n   = mem_in;
        rdata_n    = rdata;
        win_we     = pick1 ? we1 : we0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_n     = prio;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_n    = pick1;
                    gnt0_n     = !pick1;
                    gnt1_n     = pick1;
                    mem_addr_n = pick1 ? addr1 : addr0;
                    mem_in_n   = pick1 ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    prio_n     = !pick1;
`endif
                    if (win_we) begin
                        state_n  = WR;
                        mem_rw_n = 1'b1;   // write strobe covers the gnt cycle only
                    end else begin
                        state_n  = RD_SETUP;
                    end
                end
            end
            WR: begin
                state_n = IDLE;
                done0_n = !owner;
                done1_n = owner;
            end
            RD_SETUP: begin
                state_n = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rdata_n = mem_out;          // memory data valid during this cycle
                state_n = IDLE;
                done0_n = !owner;
                done1_n = owner;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access without a done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            mem_rw   <= 1'b0;
            mem_addr <= '0;
            mem_in   <= '0;
            rdata    <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            gnt0     <= gnt0_n;
            gnt1     <= gnt1_n;
            done0    <= done0_n;
            done1    <= done1_n;
            mem_rw   <= mem_rw_n;
            mem_addr <= mem_addr_n;
            mem_in   <= mem_in_n;
            rdata    <= rdata_n;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Priority pointer, favouring requester 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio <= 1'b0;
        else        prio <= prio_n;
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed accesses with hand-computed results.
// Drivers push expected grants and completions into queues. A negedge
// monitor pops those entries and compares them with what the DUT presents.
module tb_memory_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [2:0] addr0 = 0, addr1 = 0;
    logic [7:0] wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1, mem_rw;
    logic [7:0] rdata, mem_in, mem_out;
    logic [2:0] mem_addr;
    logic [1:0] dbg_state;

    memory_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_in(mem_in), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_out(mem_out), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / memory unit ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    // Synchronous memory unit: write on mem_rw, registered read data
    always @(posedge clk) begin
        if (mem_rw) mem[mem_addr] <= mem_in;
        mem_out <= mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [12:0] exp_gnt_q[$];   // {id, we, addr, wdata}
    logic [9:0]  exp_done_q[$];  // {id, we, rdata}
    logic [7:0]  last_rd = 8'h00; // rdata held since the last completed read

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_access(input bit id, input bit we, input logic [2:0] a,
                                 input logic [7:0] d, input logic [7:0] rd_exp);
        exp_gnt_q.push_back({id, we, a, d});
        if (!we) last_rd = rd_exp;
        exp_done_q.push_back({id, we, last_rd});
    endtask

    // ---------------- monitor ----------------
    int gcyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            logic [12:0] eg;
            logic [9:0]  ed;
            if (gnt0 && gnt1) chk("gnt_exclusive", 2'b11, 2'b01);
            if (done0 && done1) chk("done_exclusive", 2'b11, 2'b01);
            if (mem_rw && !(gnt0 || gnt1)) chk("mem_rw_outside_wr", mem_rw, 1'b0);
            if (gnt0 || gnt1) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 1'b1, 1'b0);
                else begin
                    eg = exp_gnt_q.pop_front();
                    chk("gnt_id", gnt1, eg[12]);
                    chk("gnt_mem_rw", mem_rw, eg[11]);
                    chk("gnt_mem_addr", mem_addr, eg[10:8]);
                    if (eg[11]) chk("gnt_mem_in", mem_in, eg[7:0]);
                    gcyc = cyc;
                end
            end
            if (done0 || done1) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
                else begin
                    ed = exp_done_q.pop_front();
                    chk("done_id", done1, ed[9]);
                    chk("done_latency", cyc - gcyc, ed[8] ? 1 : 2);
                    chk("rdata", rdata, ed[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit id, input bit we, input logic [2:0] a, input logic [7:0] d);
        bit got = 0;
        @(posedge clk); #1;
        if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk); #1;
            got = id ? gnt1 : gnt0;
        end
        if (!got) chk("gnt_timeout", 1'b0, 1'b1);
        if (id) req1 = 0; else req0 = 0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && (exp_gnt_q.size() != 0 || exp_done_q.size() != 0); k++)
            @(posedge clk);
        if (exp_gnt_q.size() != 0 || exp_done_q.size() != 0) begin
            chk("drain_timeout", exp_gnt_q.size() + exp_done_q.size(), 0);
            exp_gnt_q.delete();
            exp_done_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt1(output int t);
        bit got = 0;
        t = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk); #1;
            got = gnt1;
            t = cyc;
        end
        if (!got) chk("gnt1_timeout", 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t1, t2;
        // Reset state
        #2;
        chk("rst_gnt_done", {gnt0, gnt1, done0, done1}, 4'b0);
        chk("rst_mem_rw", mem_rw, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_mem_addr", mem_addr, 3'd0);
        chk("rst_mem_in", mem_in, 8'h00);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk); rst_n = 1;
        // Idle for 10 cycles: nothing moves
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_outputs", {gnt0, gnt1, done0, done1, mem_rw}, 5'b0);
        end

        // First conflict: requester 0 wins in both builds
        expect_access(0, 1, 3'd2, 8'h5A, 8'h00);
        expect_access(1, 1, 3'd5, 8'hA5, 8'h00);
        fork
            issue(0, 1, 3'd2, 8'h5A);
            issue(1, 1, 3'd5, 8'hA5);
        join
        wait_idle();

        // A lone requester-0 write, so the round-robin pointer now favours 1
        expect_access(0, 1, 3'd0, 8'h11, 8'h00);
        issue(0, 1, 3'd0, 8'h11);
        wait_idle();

        // Second conflict
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expect_access(1, 1, 3'd5, 8'hA5, 8'h00);
        expect_access(0, 1, 3'd2, 8'h5A, 8'h00);
`else
        expect_access(0, 1, 3'd2, 8'h5A, 8'h00);
        expect_access(1, 1, 3'd5, 8'hA5, 8'h00);
`endif
        fork
            issue(0, 1, 3'd2, 8'h5A);
            issue(1, 1, 3'd5, 8'hA5);
        join
        wait_idle();

        // Conflict data landed: read both back
        expect_access(1, 0, 3'd2, 8'h00, 8'h5A);
        issue(1, 0, 3'd2, 8'h00);
        wait_idle();
        expect_access(0, 0, 3'd5, 8'h00, 8'hA5);
        issue(0, 0, 3'd5, 8'h00);
        wait_idle();

        // Requester 0 writes i to address i, then reads each back
        for (int i = 0; i < 8; i++) begin
            expect_access(0, 1, i[2:0], i[7:0], 8'h00);
            issue(0, 1, i[2:0], i[7:0]);
            wait_idle();
        end
        for (int i = 0; i < 8; i++) begin
            expect_access(0, 0, i[2:0], 8'h00, i[7:0]);
            issue(0, 0, i[2:0], 8'h00);
            wait_idle();
        end

        // req1 held through its done: the next access starts in the done cycle
        expect_access(1, 1, 3'd3, 8'h33, 8'h00);
        expect_access(1, 0, 3'd3, 8'h33, 8'h33);
        @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 3'd3; wdata1 = 8'h33;
        wait_gnt1(t1);
        we1 = 0;
        wait_gnt1(t2);
        req1 = 0;
        chk("b2b_gnt_spacing", t2 - t1, 2);
        wait_idle();

        // Reset in the middle of a write
        exp_gnt_q.push_back({1'b0, 1'b1, 3'd6, 8'h77});
        issue(0, 1, 3'd6, 8'h77);
        chk("wr_mem_rw_high", mem_rw, 1'b1);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        chk("abort_mem_rw", mem_rw, 1'b0);
        chk("abort_outputs", {gnt0, gnt1, done0, done1, mem_addr, mem_in, rdata}, 23'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {done0, done1, mem_rw}, 3'b0);
        end
        @(negedge clk); rst_n = 1;
        last_rd = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", {done0, done1, mem_rw}, 3'b0);
        end
        expect_access(0, 1, 3'd6, 8'h66, 8'h00);
        issue(0, 1, 3'd6, 8'h66);
        wait_idle();
        expect_access(1, 0, 3'd6, 8'h00, 8'h66);
        issue(1, 0, 3'd6, 8'h00);
        wait_idle();

        chk("queues_drained", exp_gnt_q.size() + exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
